// File: rtl/icache_nway_if.sv
// icache_nway_if: requester and physical-memory signals of the instruction cache.
//   slave  : cache side (takes the fetch request and fill data; drives busy,
//            the response, and the fill request).
//   master : environment side (fetch stage plus pmem arbiter/adapter).
// Signals:
//   mem_address/mem_read          fetch request
//   busy/mem_resp/mem_rdata256    accept stall, response valid, line data
//   pmem_read/pmem_address        line fill request, line-aligned address
//   pmem_resp/pmem_rdata          fill data valid, fill data
interface icache_nway_if #(
  parameter int S_LINE = 256
);
  logic [31:0]       mem_address;
  logic              mem_read;
  logic              busy;
  logic              mem_resp;
  logic [S_LINE-1:0] mem_rdata256;
  logic              pmem_read;
  logic [31:0]       pmem_address;
  logic              pmem_resp;
  logic [S_LINE-1:0] pmem_rdata;

  modport slave (
    input  mem_address, mem_read, pmem_resp, pmem_rdata,
    output busy, mem_resp, mem_rdata256, pmem_read, pmem_address
  );

  modport master (
    output mem_address, mem_read, pmem_resp, pmem_rdata,
    input  busy, mem_resp, mem_rdata256, pmem_read, pmem_address
  );
endinterface

// File: rtl/icache_nway.sv
// icache_nway: pipelined read-only N-way set-associative instruction cache.
// A request is accepted into stage 2 when mem_read & ~busy. Stage 2 compares
// tags; a hit answers in that cycle with the full line, a miss enters FILL,
// fetches the line from pmem into a victim way (lowest invalid way, else the
// tree pseudo-LRU choice) and bypasses the fill data to the requester.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           icache_nway_if.slave (requester and pmem signals)
//   perf_hits     hit response counter (saturating)
//   perf_misses   fill entry counter (saturating)
// Build option: define ICACHE_PERF_EN to build the performance counters;
// otherwise both counter ports are tied to zero.
module icache_nway #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4
) (
  input  logic         clk,
  input  logic         rst,
  icache_nway_if.slave bus,
  output logic [31:0]  perf_hits,
  output logic [31:0]  perf_misses
);
  localparam int S_LINE = 8 * (2 ** S_OFFSET);
  localparam int S_TAG  = 32 - S_OFFSET - S_INDEX;
  localparam int NSETS  = 2 ** S_INDEX;
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int LA_W   = 32 - S_OFFSET;

  typedef enum logic {RUN, FILL} state_e;

  state_e          state_q, state_d;
  logic            s2_valid_q, s2_valid_d;
  logic [LA_W-1:0] s2_line_q, s2_line_d;   // line address {tag,index}

  logic [NUM_WAYS-1:0] valid_q [NSETS];
  logic [S_TAG-1:0]    tag_q   [NSETS][NUM_WAYS];
  logic [S_LINE-1:0]   data_q  [NSETS][NUM_WAYS];
  logic [NUM_WAYS-2:0] plru_q  [NSETS];     // heap order: node n -> 2n+1, 2n+2

  logic [S_TAG-1:0]    s2_tag;
  logic [S_INDEX-1:0]  s2_idx;
  logic [NUM_WAYS-1:0] match;
  logic                hit, hit_resp, fill_go;
  logic [WAY_W-1:0]    hit_way, victim, acc_way;
  logic [NUM_WAYS-2:0] plru_cur, plru_new;

  assign s2_tag = s2_line_q[LA_W-1 -: S_TAG];
  assign s2_idx = s2_line_q[S_INDEX-1:0];

  // Arrays are read with the stage-2 index, so a fill written at the
  // pmem_resp edge is visible to the very next lookup.
  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      match[w] = valid_q[s2_idx][w] && (tag_q[s2_idx][w] == s2_tag);
      if (match[w]) hit_way = WAY_W'(w);
    end
    hit = s2_valid_q && (|match);
  end

  // Victim: walk the tree (node bit 1 = upper half), then any invalid way
  // overrides, lowest index winning.
  always_comb begin
    int node;
    node     = 0;
    victim   = '0;
    plru_cur = plru_q[s2_idx];
    for (int l = 0; l < WAY_W; l++) begin
      victim[WAY_W-1-l] = plru_cur[node];
      node = 2 * node + 1 + int'(plru_cur[node]);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[s2_idx][w]) victim = WAY_W'(w);
  end

  always_comb begin
    state_d    = state_q;
    s2_valid_d = s2_valid_q;
    s2_line_d  = s2_line_q;
    hit_resp   = 1'b0;
    fill_go    = 1'b0;
    bus.busy         = (state_q == FILL) || (s2_valid_q && !hit);
    bus.pmem_read    = (state_q == FILL);
    bus.pmem_address = {s2_line_q, {S_OFFSET{1'b0}}};
    bus.mem_rdata256 = data_q[s2_idx][hit_way];
    case (state_q)
      RUN: if (s2_valid_q) begin
        if (hit) begin
          hit_resp   = !rst;
          s2_valid_d = 1'b0;
        end else begin
          state_d = FILL;
        end
      end
      FILL: if (bus.pmem_resp) begin
        fill_go          = !rst;
        bus.mem_rdata256 = bus.pmem_rdata;
        s2_valid_d       = 1'b0;
        state_d          = RUN;
      end
      default: state_d = RUN;
    endcase
    bus.mem_resp = hit_resp || fill_go;
    if (bus.mem_read && !bus.busy) begin
      s2_valid_d = 1'b1;
      s2_line_d  = bus.mem_address[31:S_OFFSET];
    end
  end

  // Touching a way points every node on its path at the other subtree.
  always_comb begin
    int node;
    node     = 0;
    plru_new = plru_cur;
    acc_way  = fill_go ? victim : hit_way;
    for (int l = 0; l < WAY_W; l++) begin
      plru_new[node] = ~acc_way[WAY_W-1-l];
      node = 2 * node + 1 + int'(acc_way[WAY_W-1-l]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      s2_valid_q <= 1'b0;
      s2_line_q  <= '0;
    end else begin
      state_q    <= state_d;
      s2_valid_q <= s2_valid_d;
      s2_line_q  <= s2_line_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (fill_go) valid_q[s2_idx][victim] <= 1'b1;
      if (fill_go || hit_resp) plru_q[s2_idx] <= plru_new;
    end
  end

  // Tag and data need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_go) begin
      tag_q[s2_idx][victim]  <= s2_tag;
      data_q[s2_idx][victim] <= bus.pmem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && s2_valid_q) assert ($onehot0(match));
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d;
  logic        miss;

  assign miss = (state_q == RUN) && s2_valid_q && !hit;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (hit_resp && (hits_q != '1)) hits_d   = hits_q + 32'd1;
    if (miss && (misses_q != '1))   misses_d = misses_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
`endif
endmodule

// File: tb/tb_icache_nway.sv
module tb_icache_nway;
`ifdef ICACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] perf_hits, perf_misses;

  always #5 clk = ~clk;

  icache_nway_if #(.S_LINE(256)) bus();

  icache_nway #(.S_OFFSET(5), .S_INDEX(3), .NUM_WAYS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .perf_hits(perf_hits), .perf_misses(perf_misses)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: per set, 4 ways of {valid, tag}; the PLRU tree is kept as
  // node[level][path prefix], victim found by descending the prefixes.
  bit          m_valid [8][4];
  int unsigned m_tag   [8][4];
  bit          m_node  [8][2][2];
  int unsigned exp_hits, exp_misses;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] r;
    for (int k = 0; k < 8; k++)
      r[k*32 +: 32] = ((a >> 5) * 32'h9E3779B1) ^ (k * 32'h01010101) ^ 32'hA5A5_0000;
    return r;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 4; w++) begin m_valid[s][w] = 0; m_tag[s][w] = 0; end
      for (int l = 0; l < 2; l++) for (int p = 0; p < 2; p++) m_node[s][l][p] = 0;
    end
    exp_hits = 0; exp_misses = 0;
  endfunction

  function automatic int model_find(input logic [31:0] a);
    int s;
    s = int'((a >> 5) & 7);
    for (int w = 0; w < 4; w++)
      if (m_valid[s][w] && m_tag[s][w] == (a >> 8)) return w;
    return -1;
  endfunction

  function automatic void model_touch(input int s, input int w);
    for (int l = 0; l < 2; l++)
      m_node[s][l][w >> (2 - l)] = (((w >> (1 - l)) & 1) == 0);
  endfunction

  function automatic int model_victim(input int s);
    int w;
    for (int i = 0; i < 4; i++) if (!m_valid[s][i]) return i;
    w = 0;
    for (int l = 0; l < 2; l++) w = (w << 1) | int'(m_node[s][l][w]);
    return w;
  endfunction

  task automatic reset_dut();
    rst = 1'b1; bus.mem_read = 1'b0; bus.pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One complete read transaction; dut_hit reports whether the DUT answered
  // in the cycle after acceptance.
  task automatic do_read(input logic [31:0] a, input int dly, input string nm, output bit dut_hit);
    int s, way;
    logic [255:0] ln;
    s = int'((a >> 5) & 7); way = model_find(a); ln = line_of(a);
    @(posedge clk); #1 bus.mem_address = a; bus.mem_read = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL %s accept busy: got %b want 0", nm, bus.busy); end
    @(posedge clk); #1 bus.mem_read = 1'b0; bus.mem_address = $urandom;
    @(negedge clk);
    dut_hit = (bus.mem_resp === 1'b1);
    if (way >= 0) begin
      n_vec++; if (bus.mem_resp !== 1'b1) begin n_err++; $display("FAIL %s hit resp: got %b want 1", nm, bus.mem_resp); end
      n_vec++; if (bus.mem_rdata256 !== ln) begin n_err++; $display("FAIL %s hit data: got %h want %h", nm, bus.mem_rdata256, ln); end
      n_vec++; if (bus.pmem_read !== 1'b0) begin n_err++; $display("FAIL %s hit pmem_read: got %b want 0", nm, bus.pmem_read); end
      model_touch(s, way); exp_hits++;
    end else begin
      n_vec++; if (bus.mem_resp !== 1'b0) begin n_err++; $display("FAIL %s miss resp: got %b want 0", nm, bus.mem_resp); end
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL %s miss busy: got %b want 1", nm, bus.busy); end
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++; if (bus.pmem_read !== 1'b1) begin n_err++; $display("FAIL %s pmem_read rise: got %b want 1", nm, bus.pmem_read); end
      n_vec++; if (bus.pmem_address !== (a & ~32'h1F)) begin n_err++; $display("FAIL %s pmem_address: got %h want %h", nm, bus.pmem_address, a & ~32'h1F); end
      repeat (dly - 1) begin
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if (bus.pmem_read !== 1'b1 || bus.mem_resp !== 1'b0) begin n_err++; $display("FAIL %s fill wait: got pmem_read=%b resp=%b want 1/0", nm, bus.pmem_read, bus.mem_resp); end
      end
      @(posedge clk); #1 bus.pmem_resp = 1'b1; bus.pmem_rdata = ln;
      @(negedge clk);
      n_vec++; if (bus.mem_resp !== 1'b1) begin n_err++; $display("FAIL %s bypass resp: got %b want 1", nm, bus.mem_resp); end
      n_vec++; if (bus.mem_rdata256 !== ln) begin n_err++; $display("FAIL %s bypass data: got %h want %h", nm, bus.mem_rdata256, ln); end
      @(posedge clk); #1 bus.pmem_resp = 1'b0; bus.pmem_rdata = {8{$urandom}};
      @(negedge clk);
      n_vec++; if (bus.pmem_read !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL %s after fill: got pmem_read=%b busy=%b want 0/0", nm, bus.pmem_read, bus.busy); end
      way = model_victim(s);
      m_valid[s][way] = 1; m_tag[s][way] = a >> 8;
      model_touch(s, way); exp_misses++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.mem_read = 1'b1; bus.mem_address = 32'h104; bus.pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; bus.mem_read = 1'b0;
    model_reset();
    @(negedge clk);
    n_vec++; if (bus.mem_resp !== 1'b0) begin n_err++; $display("FAIL reset mem_resp: got %b want 0", bus.mem_resp); end
    n_vec++; if (bus.pmem_read !== 1'b0) begin n_err++; $display("FAIL reset pmem_read: got %b want 0", bus.pmem_read); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset busy (reset beats request): got %b want 0", bus.busy); end
    n_vec++; if (perf_hits !== 32'd0 || perf_misses !== 32'd0) begin n_err++; $display("FAIL reset perf: got %0d/%0d want 0/0", perf_hits, perf_misses); end
  endtask

  task automatic test_cold_miss_and_hit();
    bit h;
    reset_dut();
    do_read(32'h0000_0104, 5, "cold_miss", h);
    n_vec++; if (h !== 1'b0) begin n_err++; $display("FAIL cold_miss kind: got hit=%b want 0", h); end
    do_read(32'h0000_0118, 1, "hit_after_fill", h);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL hit_after_fill kind: got hit=%b want 1", h); end
  endtask

  task automatic test_back_to_back();
    bit h;
    logic [31:0] prev;
    reset_dut();
    do_read(32'h000, 2, "b2b_pre0", h);
    do_read(32'h020, 2, "b2b_pre1", h);
    prev = 0;
    for (int i = 0; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        bus.mem_address = (i % 2 == 1) ? 32'h020 : 32'h000; bus.mem_read = 1'b1;
      end else bus.mem_read = 1'b0;
      @(negedge clk);
      if (i < 8) begin
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b busy cyc%0d: got %b want 0", i, bus.busy); end
      end
      if (i > 0) begin
        n_vec++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata256 !== line_of(prev)) begin n_err++; $display("FAIL b2b resp cyc%0d: got resp=%b data=%h want 1/%h", i, bus.mem_resp, bus.mem_rdata256, line_of(prev)); end
        model_touch(int'((prev >> 5) & 7), model_find(prev)); exp_hits++;
      end
      prev = bus.mem_address;
    end
  endtask

  task automatic test_plru_eviction();
    bit h;
    reset_dut();
    do_read(32'h000, 1, "ev_fill0", h);
    do_read(32'h100, 2, "ev_fill1", h);
    do_read(32'h200, 1, "ev_fill2", h);
    do_read(32'h300, 3, "ev_fill3", h);
    do_read(32'h000, 1, "ev_hit0", h);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL ev_hit0 kind: got hit=%b want 1", h); end
    do_read(32'h400, 2, "ev_miss4", h);
    n_vec++; if (h !== 1'b0) begin n_err++; $display("FAIL ev_miss4 kind: got hit=%b want 0", h); end
    do_read(32'h100, 1, "ev_keep1", h);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL ev_keep1 kind: got hit=%b want 1", h); end
    do_read(32'h200, 1, "ev_gone2", h);
    n_vec++; if (h !== 1'b0) begin n_err++; $display("FAIL ev_gone2 kind: got hit=%b want 0", h); end
    n_vec++; if (perf_misses !== (PERF ? 32'd6 : 32'd0)) begin n_err++; $display("FAIL ev perf_misses: got %0d want %0d", perf_misses, PERF ? 6 : 0); end
    n_vec++; if (perf_hits !== (PERF ? 32'd2 : 32'd0)) begin n_err++; $display("FAIL ev perf_hits: got %0d want %0d", perf_hits, PERF ? 2 : 0); end
  endtask

  task automatic test_reset_mid_fill();
    bit h;
    reset_dut();
    @(posedge clk); #1 bus.mem_address = 32'h040; bus.mem_read = 1'b1;
    @(posedge clk); #1 bus.mem_read = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (bus.pmem_read !== 1'b1) begin n_err++; $display("FAIL midfill enter: got pmem_read=%b want 1", bus.pmem_read); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.mem_resp !== 1'b0) begin n_err++; $display("FAIL midfill resp in rst: got %b want 0", bus.mem_resp); end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_vec++; if (bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0) begin n_err++; $display("FAIL midfill after rst: got pmem_read=%b resp=%b want 0/0", bus.pmem_read, bus.mem_resp); end
    @(posedge clk); #1 bus.pmem_resp = 1'b1; bus.pmem_rdata = line_of(32'h040);
    @(negedge clk);
    n_vec++; if (bus.mem_resp !== 1'b0) begin n_err++; $display("FAIL midfill late pmem_resp: got resp=%b want 0", bus.mem_resp); end
    @(posedge clk); #1 bus.pmem_resp = 1'b0;
    do_read(32'h040, 2, "midfill_reread", h);
    n_vec++; if (h !== 1'b0) begin n_err++; $display("FAIL midfill_reread kind: got hit=%b want 0", h); end
  endtask

  task automatic test_random();
    bit h;
    logic [31:0] a;
    reset_dut();
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
      do_read(a, $urandom_range(1, 4), "rand", h);
    end
    n_vec++; if (perf_hits !== (PERF ? exp_hits : 32'd0)) begin n_err++; $display("FAIL rand perf_hits: got %0d want %0d", perf_hits, PERF ? exp_hits : 0); end
    n_vec++; if (perf_misses !== (PERF ? exp_misses : 32'd0)) begin n_err++; $display("FAIL rand perf_misses: got %0d want %0d", perf_misses, PERF ? exp_misses : 0); end
  endtask

  initial begin
    bus.mem_address = 32'h0; bus.mem_read = 1'b0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0; rst = 1'b1;
    test_reset();
    test_cold_miss_and_hit();
    test_back_to_back();
    test_plru_eviction();
    test_reset_mid_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/icache_nway.md
# icache_nway

Parametrised, pipelined, read-only N-way set-associative instruction cache, combining datapath and controller in one block. Sits between the fetch stage and the physical-memory arbiter/cacheline adapter. Hits return one full cacheline one cycle after acceptance, at one request per cycle. Misses stall, fill from pmem using a victim chosen by tree pseudo-LRU, and bypass the fill data to the requester.

## Interface
Parameters:
- S_OFFSET, 5, log2 bytes per line; line width S_LINE = 8*2^S_OFFSET.
- S_INDEX, 3, log2 sets; index = address[S_OFFSET+S_INDEX-1:S_OFFSET].
- NUM_WAYS, 4, power of two, 2..8; tag width S_TAG = 32-S_OFFSET-S_INDEX.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock.
  - rst  in  1  synchronous, active-high reset.
- Requester side:
  - mem_address  in  32  fetch address.
  - mem_read  in  1  request valid.
  - busy  out  1  combinational; request not accepted this cycle.
  - mem_resp  out  1  response valid.
  - mem_rdata256  out  S_LINE  line data; don't-care when mem_resp=0.
- Physical-memory side:
  - pmem_read  out  1  line fill request.
  - pmem_address  out  32  line-aligned fill address {tag,index,0}.
  - pmem_resp  in  1  fill data valid.
  - pmem_rdata  in  S_LINE  fill data.
- Performance counters:
  - perf_hits  out  32  hit counter (see Configuration).
  - perf_misses  out  32  miss counter (see Configuration).

## Operation
- Storage per set: NUM_WAYS × {valid, tag, line}, plus NUM_WAYS-1 PLRU tree bits.
- Stage 1 (accept): a request is accepted when mem_read=1 and busy=0. The index is read from the arrays, and address is captured into stage-2 register s2 with s2_valid set.
- Stage 2 (compare):
  - hit = s2_valid and any way with valid and tag == s2 tag.
  - Ways are one-hot by construction; more than one match is an assertion error.
- Controller states:
  - RUN:
    - s2 hit: mem_resp=1, mem_rdata256 = hit way line, and the PLRU path for the hit way is updated.
    - s2 miss: move to FILL next cycle; busy=1 this cycle.
  - FILL:
    - pmem_read=1 and busy=1 are held until pmem_resp.
    - On pmem_resp, in the same cycle: write pmem_rdata, s2 tag and valid=1 into the victim way; update PLRU; mem_resp=1 with mem_rdata256=pmem_rdata (bypass); clear s2_valid; move to RUN next cycle.
- busy = (state==FILL) | (s2_valid & ~hit).
- Victim selection: the lowest-indexed invalid way. If all ways are valid, follow the PLRU tree.
- PLRU rule:
  - Each node bit selects the victim subtree: 0 = lower half, 1 = upper half.
  - Accessing way w sets every node on w's path to point away from w.
  - With NUM_WAYS=2 this reduces to a single LRU bit.
- Requester holds mem_address/mem_read while busy=1. Requests presented while busy=1 are ignored.
- No writes: mem_rdata256 is the sole data output.

## Timing
- Hit latency: 1 cycle (accept at edge N, mem_resp high during cycle N+1). Back-to-back hits: one response per cycle, no bubbles.
- Miss latency: 1 compare cycle, then 1 cycle to enter FILL, then the pmem wait; mem_resp is coincident with pmem_resp. The next request can be accepted the cycle after pmem_resp.
- pmem_read rises the cycle after the miss compare and falls the cycle after pmem_resp.
- Hit immediately after a fill to the same line: the array write happens at the pmem_resp edge, so the following lookup sees the new line.
- Reset values:
  - Outputs: mem_resp=0, pmem_read=0, busy=0, perf counters=0.
  - Internal: all valid bits 0, PLRU bits 0, state=RUN, s2_valid=0.
- Reset during FILL: the fill is abandoned, with no array write and no mem_resp. pmem_read is 0 the cycle after reset is sampled. A pmem_resp arriving later is ignored.
- rst and mem_read together: reset wins and the request is not accepted.

## Configuration
- ICACHE_PERF_EN defined:
  - perf_hits increments on each RUN-state hit response.
  - perf_misses increments on each transition into FILL.
  - Both are 32-bit and saturate at 0xFFFF_FFFF.
- Not defined: both ports are driven constant 0 and no counter flops exist; all other behaviour is identical.

## Test plan
All scenarios use the defaults (S_OFFSET=5, S_INDEX=3, NUM_WAYS=4).
- Cold miss: after reset, read 0x0000_0104 -> pmem_read=1 with pmem_address=0x0000_0100. Hold pmem_resp low for 5 cycles, then drive line L -> mem_resp=1 with mem_rdata256=L in the same cycle; busy=0 on the next cycle.
- Hit after fill: read 0x0000_0118 -> mem_resp=1 one cycle after acceptance with data L; pmem_read stays 0.
- Back-to-back hits: preload 0x000 and 0x020, then issue alternating reads on 8 consecutive cycles -> 8 consecutive mem_resp with no busy.
- PLRU eviction: fill 0x000, 0x100, 0x200, 0x300 (all index 0, ways 0..3), then read 0x000 (hit), then read 0x400 -> miss evicts way 2 (tag of 0x200). A subsequent read of 0x100 hits; a subsequent read of 0x200 misses.
- Reset mid-fill: assert rst for 1 cycle during FILL -> pmem_read=0 the next cycle, no mem_resp. Re-reading the same address misses again.
- Perf counters (ICACHE_PERF_EN): run the eviction sequence -> perf_misses=6 and perf_hits=2 at its end.
